ps2_key_receiver: RTL and testbench

- Receives PS/2 keyboard frames from the Basys2 PS/2 port and turns make/break scan-code sequences into a held 8-bit key_code.
- key_code is the scan-code bus that the note-display and tone blocks consume: Set-2 codes such as 0x15 for Q or 0x1C for A, and 0x00 when no key is held.
- Runs in the 50 MHz system clock domain. The asynchronous PS/2 lines are synchronised and filtered internally.

---
 rtl/ps2_key_receiver.sv | 168 ++++++++++++++++
 tb/tb_ps2_key_receiver.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 lines, frames 11-bit words
// and turns Set-2 make/break sequences into a held key_code. Optional macro: PS2_PARITY_CHECK_EN.
module ps2_key_receiver #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [1:0]    clk_sync_reg;
    logic [1:0]    data_sync_reg;
    logic [FW-1:0] filt_cnt_reg;
    logic          filt_clk_reg;
    logic          fall_reg;

    state_t        state_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic [TW-1:0] tmo_cnt_reg;
    logic          brk_flag_reg;
    logic          ext_flag_reg;
    logic [7:0]    key_code_reg;
    logic          key_valid_reg;
    logic          frame_err_reg;
`ifdef PS2_PARITY_CHECK_EN
    logic          parity_reg;
    logic          parity_ok;
    assign parity_ok = ^{shift_reg, parity_reg};
`endif

    logic data_bit;
    assign data_bit = data_sync_reg[1];

    // Lines idle high, so synchronisers and filter come out of reset at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_reg  <= 2'b11;
            data_sync_reg <= 2'b11;
            filt_cnt_reg  <= '0;
            filt_clk_reg  <= 1'b1;
            fall_reg      <= 1'b0;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
            data_sync_reg <= {data_sync_reg[0], ps2_data};
            fall_reg      <= 1'b0;
            if (clk_sync_reg[1] == filt_clk_reg) begin
                filt_cnt_reg <= '0;
            end else if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
                filt_clk_reg <= clk_sync_reg[1];
                filt_cnt_reg <= '0;
                fall_reg     <= filt_clk_reg;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            tmo_cnt_reg   <= '0;
            brk_flag_reg  <= 1'b0;
            ext_flag_reg  <= 1'b0;
            key_code_reg  <= 8'h00;
            key_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_reg    <= 1'b0;
`endif
        end else begin
            key_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;

            if (state_reg != IDLE && !fall_reg) begin
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end else begin
                tmo_cnt_reg <= '0;
            end

            if (state_reg != IDLE && !fall_reg && tmo_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
                frame_err_reg <= 1'b1;
                state_reg     <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        bit_cnt_reg <= '0;
                        if (fall_reg) begin
                            if (!data_bit) begin
                                state_reg <= DATA;
                            end else begin
                                frame_err_reg <= 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        if (fall_reg) begin
                            shift_reg   <= {data_bit, shift_reg[7:1]};
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            if (bit_cnt_reg == 3'd7) begin
                                state_reg <= PARITY;
                            end
                        end
                    end
                    PARITY: begin
                        if (fall_reg) begin
`ifdef PS2_PARITY_CHECK_EN
                            parity_reg <= data_bit;
`endif
                            state_reg  <= STOP;
                        end
                    end
                    STOP: begin
                        if (fall_reg) begin
                            state_reg <= IDLE;
                            if (!data_bit) begin
                                frame_err_reg <= 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                            end else if (!parity_ok) begin
                                frame_err_reg <= 1'b1;
`endif
                            end else if (shift_reg == 8'hE0) begin
                                ext_flag_reg <= 1'b1;
                            end else if (shift_reg == 8'hF0) begin
                                brk_flag_reg <= 1'b1;
                            end else if (ext_flag_reg) begin
                                // Extended keys are consumed here and never reach key_code.
                                ext_flag_reg <= 1'b0;
                                brk_flag_reg <= 1'b0;
                            end else if (brk_flag_reg) begin
                                if (shift_reg == key_code_reg) begin
                                    key_code_reg <= 8'h00;
                                end
                                brk_flag_reg <= 1'b0;
                            end else begin
                                key_code_reg  <= shift_reg;
                                key_valid_reg <= 1'b1;
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign key_code  = key_code_reg;
    assign key_valid = key_valid_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Scoreboarded bench for ps2_key_receiver: keyboard frames are driven with a scaled-down
// PS/2 clock, expected pulses are queued and matched by a monitor on the falling clk edge.
module tb_ps2_key_receiver;

    localparam int H       = 60;    // clk cycles per PS/2 clock half-period
    localparam int TIMEOUT = 1000;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_code;
    logic       key_valid;
    logic       frame_err;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_kv = 1'b0;

    ps2_key_receiver #(
        .FILTER_LEN (8),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_code (key_code),
        .key_valid(key_valid),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic push_exp(input bit is_err, input logic [7:0] code);
        exp_t e;
        e.is_err = is_err;
        e.code   = code;
        exp_q.push_back(e);
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) drive_bit(f[i]);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (3 * H) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11);
    endtask

    // Every output pulse must match the head of the queue, including key_code at that moment.
    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid || frame_err) begin
                check_eq("pulse_exclusive", {31'd0, key_valid & frame_err}, 32'd0);
                if (key_valid) check_eq("kv_one_cycle", {31'd0, prev_kv}, 32'd0);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_pulse", {30'd0, key_valid, frame_err}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq(e.is_err ? "err_pulse" : "valid_pulse", {31'd0, frame_err},
                             {31'd0, e.is_err});
                    check_eq("pulse_code", {24'd0, key_code}, {24'd0, e.code});
                end
            end
            prev_kv <= key_valid;
        end
    end

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("reset_code", {24'd0, key_code}, 32'h00);
        check_eq("reset_valid", {31'd0, key_valid}, 32'd0);
        check_eq("reset_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        push_exp(1'b0, 8'h15);
        send(8'h15);
        check_eq("make_15", {24'd0, key_code}, 32'h15);

        push_exp(1'b0, 8'h1C);
        send(8'h1C); send(8'hF0); send(8'h1C);
        check_eq("break_1c", {24'd0, key_code}, 32'h00);

        push_exp(1'b0, 8'h15); push_exp(1'b0, 8'h1C);
        send(8'h15); send(8'h1C); send(8'hF0); send(8'h15);
        check_eq("stale_break", {24'd0, key_code}, 32'h1C);

        for (int i = 0; i < 3; i++) begin
            push_exp(1'b0, 8'h1C);
            send(8'h1C);
        end
        check_eq("typematic", {24'd0, key_code}, 32'h1C);

        push_exp(1'b0, 8'h23);
        send(8'h23);
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        check_eq("extended_ignored", {24'd0, key_code}, 32'h23);

        // Clock stalls after 4 data bits, well past the timeout.
        push_exp(1'b1, 8'h23);
        send_frame(8'h5A, 1'b0, 1'b0, 5);
        repeat (TIMEOUT + 500) @(negedge clk);
        push_exp(1'b0, 8'h24);
        send(8'h24);
        check_eq("after_timeout", {24'd0, key_code}, 32'h24);

        push_exp(1'b1, 8'h24);
        drive_bit(1'b1);
        repeat (3 * H) @(negedge clk);

        push_exp(1'b1, 8'h24);
        send_frame(8'h33, 1'b0, 1'b1, 11);
        check_eq("bad_stop", {24'd0, key_code}, 32'h24);

`ifdef PS2_PARITY_CHECK_EN
        push_exp(1'b1, 8'h24);
        send_frame(8'h15, 1'b1, 1'b0, 11);
        check_eq("bad_parity", {24'd0, key_code}, 32'h24);
`else
        push_exp(1'b0, 8'h15);
        send_frame(8'h15, 1'b1, 1'b0, 11);
        check_eq("parity_ignored", {24'd0, key_code}, 32'h15);
`endif

        // Leave a break prefix pending and abort mid-frame with reset; the prefix must be lost.
        send(8'hF0);
        send_frame(8'h2B, 1'b0, 1'b0, 5);
        #3 rst = 1'b1;
        #1;
        check_eq("midrst_code", {24'd0, key_code}, 32'h00);
        check_eq("midrst_valid", {31'd0, key_valid}, 32'd0);
        check_eq("midrst_err", {31'd0, frame_err}, 32'd0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (4 * H) @(negedge clk);
        push_exp(1'b0, 8'h2B);
        send(8'h2B);
        check_eq("post_reset_make", {24'd0, key_code}, 32'h2B);

        repeat (20) @(negedge clk);
        check_eq("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
